// File: rtl/fpga_cfg_pkg.sv
// Shared types and CRC-8 helper for the FPGA configuration loader.
package fpga_cfg_pkg;

    localparam logic [7:0] CRC_INIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        CHECK  = 3'd3,
        COMMIT = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } cfg_state_t;

    // One byte of CRC-8, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Running CRC-8 over accepted bitstream bytes; clear has priority over update.
module cfg_crc8
    import fpga_cfg_pkg::*;
#(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_upd,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CRC_INIT;
        end else if (i_upd) begin
            r_crc <= crc8_byte(r_crc, i_data, POLY);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-stream to config-chain loader: shifts bytes LSB first, checks a trailing
// CRC-8 byte, then latches the chain and releases the fabric from reset.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 256,
    parameter logic [7:0]  CRC_POLY  = 8'h07
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cfg_start,
    input  logic       i_cfg_abort,
    input  logic [7:0] i_cfg_data,
    input  logic       i_cfg_valid,
    output logic       o_cfg_ready,
    output logic       o_chain_en,
    output logic       o_chain_din,
    output logic       o_chain_latch,
    output logic       o_fabric_rst_n,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int unsigned N_BYTES = CHAIN_LEN / 8;
    localparam int unsigned BCW     = $clog2(N_BYTES + 1);

    if ((CHAIN_LEN % 8) != 0 || CHAIN_LEN < 8) begin : g_bad_chain_len
        $error("CHAIN_LEN must be a multiple of 8 and at least 8");
    end

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [BCW-1:0]   r_byte_cnt;
    logic [BCW-1:0]   w_byte_cnt_inc;
    logic             w_last_byte;
    logic             w_hs;
    logic             w_start_go;
    logic             w_load_go;
    logic             w_shift_go;
    logic [7:0]       w_crc;

    logic r_cfg_ready, r_chain_en, r_chain_latch, r_fabric_rst_n, r_busy, r_done, r_err;
    logic w_ready_nxt, w_en_nxt, w_latch_nxt, w_frst_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

    assign w_hs           = i_cfg_valid && r_cfg_ready;
    assign w_byte_cnt_inc = r_byte_cnt + BCW'(1);
    assign w_last_byte    = (w_byte_cnt_inc == BCW'(N_BYTES));

    cfg_crc8 #(
        .POLY   (CRC_POLY)
    ) u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start_go),
        .i_upd  (w_load_go),
        .i_data (i_cfg_data),
        .o_crc  (w_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus output decode; outputs follow the next state so they register in step with it.
    always_comb begin
        w_state_nxt = r_state;
        w_start_go  = 1'b0;
        w_load_go   = 1'b0;
        w_shift_go  = 1'b0;
        unique case (r_state)
            IDLE, DONE, ERR: begin
                if (i_cfg_start) begin
                    w_state_nxt = LOAD;
                    w_start_go  = 1'b1;
                end
            end
            LOAD: begin
                if (w_hs) begin
                    w_state_nxt = SHIFT;
                    w_load_go   = 1'b1;
                end
            end
            SHIFT: begin
                w_shift_go = 1'b1;
                if (r_bit_cnt == 3'd7) begin
                    w_state_nxt = w_last_byte ? CHECK : LOAD;
                end
            end
            CHECK: begin
                if (w_hs) begin
                    w_state_nxt = (i_cfg_data == w_crc) ? COMMIT : ERR;
                end
            end
            COMMIT:  w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (i_cfg_abort) begin
            w_state_nxt = IDLE;
            w_start_go  = 1'b0;
            w_load_go   = 1'b0;
            w_shift_go  = 1'b0;
        end

        w_ready_nxt = (w_state_nxt == LOAD) || (w_state_nxt == CHECK);
        w_en_nxt    = (w_state_nxt == SHIFT);
        w_latch_nxt = (w_state_nxt == COMMIT);
        w_busy_nxt  = (w_state_nxt == LOAD) || (w_state_nxt == SHIFT) ||
                      (w_state_nxt == CHECK) || (w_state_nxt == COMMIT);
        w_done_nxt  = (w_state_nxt == DONE);
        w_err_nxt   = (w_state_nxt == ERR);
        w_frst_nxt  = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_ready    <= 1'b0;
            r_chain_en     <= 1'b0;
            r_chain_latch  <= 1'b0;
            r_fabric_rst_n <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_cfg_ready    <= w_ready_nxt;
            r_chain_en     <= w_en_nxt;
            r_chain_latch  <= w_latch_nxt;
            r_fabric_rst_n <= w_frst_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_err          <= w_err_nxt;
        end
    end

    // Byte shift register and bit/byte counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
        end else begin
            if (w_start_go) begin
                r_byte_cnt <= '0;
                r_bit_cnt  <= 3'd0;
            end
            if (w_load_go) begin
                r_shift   <= i_cfg_data;
                r_bit_cnt <= 3'd0;
            end
            if (w_shift_go) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_cnt <= w_byte_cnt_inc;
                end
            end
        end
    end

    assign o_cfg_ready    = r_cfg_ready;
    assign o_chain_en     = r_chain_en;
    assign o_chain_din    = r_shift[0];
    assign o_chain_latch  = r_chain_latch;
    assign o_fabric_rst_n = r_fabric_rst_n;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
Configuration controller for the custom FPGA fabric. It accepts bitstream bytes over a valid/ready byte port and serialises them into the fabric's configuration shift chain. It then checks a trailing CRC-8 byte. On a match it commits the shadow chain to active config and releases the fabric from reset. It sits between the pin-level loader interface on the top-level module and the fabric's config chain.

Parameters:
CHAIN_LEN, 256, config chain length in bits; must be a multiple of 8 and at least 8.
CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, no reflection, no final XOR.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_start  input  1  level; begins a load when the FSM is in IDLE, DONE or ERR
cfg_abort  input  1  level; abandons the load in progress and returns to IDLE
cfg_data  input  8  bitstream byte
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  byte accepted when cfg_valid && cfg_ready
chain_en  output  1  config chain shift enable
chain_din  output  1  serial bit into the chain; valid when chain_en=1
chain_latch  output  1  one-cycle pulse; chain shadow -> active config
fabric_rst_n  output  1  fabric reset; low while unconfigured or loading
busy  output  1  FSM is in LOAD, SHIFT, CHECK or COMMIT
done  output  1  configuration committed
err  output  1  CRC mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0, including fabric_rst_n; CRC register=0; counters=0.
- FSM states: IDLE, LOAD, SHIFT, CHECK, COMMIT, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR --cfg_start--> LOAD. On this transition: clear done/err, set CRC=0, byte_cnt=0, fabric_rst_n=0.
  - LOAD: cfg_ready=1. On handshake: latch the byte into a shift register, update CRC with the byte (MSB-first), go to SHIFT, bit_cnt=0.
  - SHIFT: cfg_ready=0, chain_en=1 for exactly 8 cycles. chain_din=shift_reg[0], bytes go out LSB first, shift right each cycle.
  - After bit 7: byte_cnt++. If byte_cnt == CHAIN_LEN/8, go to CHECK; else go to LOAD.
  - CHECK: cfg_ready=1. On handshake, compare cfg_data with CRC. Equal -> COMMIT; unequal -> ERR.
  - COMMIT: chain_latch=1 for one cycle, then DONE.
  - DONE: done=1, fabric_rst_n=1. ERR: err=1, fabric_rst_n=0, chain_latch never pulsed.
- Throughput: a byte accepted at cycle N produces chain_en=1 for cycles N+1..N+8; cfg_ready is high again at N+9. One byte per 9 cycles.
- No byte is dropped: cfg_valid while not ready simply waits. cfg_valid is ignored outside LOAD/CHECK.
- cfg_start while busy: ignored.
- cfg_abort (priority over all else, any busy state):
  - Next state is IDLE; chain_en drops immediately in that cycle.
  - No chain_latch; fabric_rst_n=0; done=err=0.
- cfg_abort and cfg_start together in IDLE/DONE/ERR: abort wins, stay in IDLE.
- Reset mid-load: identical to power-on reset. The partially shifted chain is never latched.
- Counter widths: bit_cnt 3 bits; byte_cnt $clog2(CHAIN_LEN/8+1) bits; no wrap is reachable.

Decomposition:
- Package fpga_cfg_pkg holds:
  - state enum cfg_state_t with the 7 states;
  - CRC_INIT=8'h00;
  - a function crc8_byte(crc, data, poly).
- One natural sub-module: cfg_crc8. It holds the CRC register with clear and update-enable inputs, instantiated once.
- All shifting and the FSM stay in fpga_cfg_loader.

Test Plan:
- CHAIN_LEN=16; start, send 0xA5, 0x3C, CRC 0xED -> chain_din sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with chain_en high for exactly those 16 cycles; one chain_latch pulse; done=1, fabric_rst_n=1, err=0.
- Same stream with CRC byte 0xEC -> err=1, done=0, fabric_rst_n=0, chain_latch never asserted.
- cfg_valid held high continuously -> cfg_ready pulses once per 9 cycles; bytes accepted in order; cfg_ready stays low during all SHIFT cycles.
- cfg_abort asserted at the 4th shift cycle of byte 1 -> next cycle state IDLE, chain_en=0, no chain_latch, busy=0. A following full valid load succeeds with done=1.
- rst_n pulsed low mid-SHIFT (asynchronously, not on a clock edge) -> all outputs 0 immediately, including fabric_rst_n and chain_en.
- From DONE, assert cfg_start -> done clears and fabric_rst_n=0 next cycle; cfg_start during LOAD is ignored, with byte_cnt unchanged.
